mult_job_issuer: RTL and testbench

- Initiator side of the start/done handshake used by the multiply/shift compute controller.
- Accepts operand pairs from upstream over valid/ready and presents them to the compute engine.
- Pulses the engine's start, waits for its done, and captures the result.
- Delivers the result downstream over valid/ready, with a timeout flag if the engine never answers.

---
 rtl/mult_job_issuer.sv | 110 +++++++++++
 tb/tb_mult_job_issuer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_job_issuer.sv
// Start/done initiator: accepts an operand pair, pulses the engine, waits for done
// (or a timeout), then holds the result until downstream takes it.
module mult_job_issuer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               eng_start,
    output logic [WIDTH-1:0]   eng_a,
    output logic [WIDTH-1:0]   eng_b,
    input  logic               eng_done,
    input  logic [2*WIDTH-1:0] eng_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               out_timeout,
    output logic               busy,
    output logic [7:0]         job_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [7:0]         job_count_q, job_count_d;
    logic               eng_start_q;
    logic [WIDTH-1:0]   eng_a_q, eng_b_q;
    logic               out_valid_q, out_timeout_q;
    logic [2*WIDTH-1:0] out_result_q;

    assign timer_d     = timer_q + CNT_W'(1);
    assign job_count_d = job_count_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            job_count_q   <= '0;
            eng_start_q   <= 1'b0;
            eng_a_q       <= '0;
            eng_b_q       <= '0;
            out_valid_q   <= 1'b0;
            out_timeout_q <= 1'b0;
            out_result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        eng_a_q     <= in_a;
                        eng_b_q     <= in_b;
                        eng_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_start_q <= 1'b0;
                    timer_q     <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    timer_q <= timer_d;
                    // done takes priority over a timeout landing on the same edge
                    if (eng_done) begin
                        out_result_q  <= eng_result;
                        out_timeout_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state_q       <= HOLD;
                    end else if (timer_q == TO_LAST) begin
                        out_result_q  <= '0;
                        out_timeout_q <= 1'b1;
                        out_valid_q   <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        job_count_q <= job_count_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign eng_start   = eng_start_q;
    assign eng_a       = eng_a_q;
    assign eng_b       = eng_b_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_timeout = out_timeout_q;
    assign job_count   = job_count_q;

endmodule

// File: tb/tb_mult_job_issuer.sv
// Bench for mult_job_issuer: transaction-timing reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mult_job_issuer;
    localparam int W  = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, eng_start, eng_done, out_valid, out_ready, out_timeout, busy;
    logic [W-1:0] in_a, in_b, eng_a, eng_b;
    logic [2*W-1:0] eng_result, out_result;
    logic [7:0] job_count;

    logic in_valid1, in_ready1, eng_start1, eng_done1, out_valid1, out_ready1, out_timeout1, busy1;
    logic [W-1:0] eng_a1, eng_b1;
    logic [2*W-1:0] eng_result1, out_result1;
    logic [7:0] job_count1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mult_job_issuer #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done),
        .eng_result(eng_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_timeout(out_timeout), .busy(busy), .job_count(job_count)
    );

    mult_job_issuer #(.WIDTH(W), .TIMEOUT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
        .eng_start(eng_start1), .eng_a(eng_a1), .eng_b(eng_b1), .eng_done(eng_done1),
        .eng_result(eng_result1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_result(out_result1), .out_timeout(out_timeout1), .busy(busy1), .job_count(job_count1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a job is described by its accept edge; WAIT edges are acc+2 .. acc+1+TO.
    bit m_busy, m_outv, m_to;
    int cyc, acc;
    logic [W-1:0] m_a, m_b;
    logic [2*W-1:0] m_res;
    logic [7:0] m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_outv = 0; m_to = 0; cyc = 0; acc = -100;
            m_a = '0; m_b = '0; m_res = '0; m_cnt = '0;
        end else begin
            cyc++;
            if (!m_busy) begin
                if (in_valid) begin m_busy = 1; acc = cyc; m_a = in_a; m_b = in_b; end
            end else if (m_outv) begin
                if (out_ready) begin m_outv = 0; m_busy = 0; m_cnt++; end
            end else if (cyc >= acc + 2) begin
                if (eng_done) begin m_outv = 1; m_res = eng_result; m_to = 0; end
                else if (cyc == acc + 1 + TO) begin m_outv = 1; m_res = '0; m_to = 1; end
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("in_ready",    in_ready,    !m_busy);
            chk("busy",        busy,        m_busy);
            chk("eng_start",   eng_start,   m_busy && (cyc == acc));
            chk("eng_a",       eng_a,       m_a);
            chk("eng_b",       eng_b,       m_b);
            chk("out_valid",   out_valid,   m_outv);
            chk("out_result",  out_result,  m_res);
            chk("out_timeout", out_timeout, m_to);
            chk("job_count",   job_count,   m_cnt);
        end
    end

    int nstart = 0;
    int tcyc = 0;
    always @(negedge clk) if (!rst && eng_start === 1'b1) nstart++;
    always @(posedge clk) tcyc++;

    // Engine stand-in: done eng_delay cycles after seeing start (0 = never), plus optional noise.
    int eng_delay = 1;
    bit noise = 0;
    bit use_force = 0;
    logic [2*W-1:0] force_res = '0;
    initial begin
        int cnt;
        cnt = 0;
        eng_done = 1'b0;
        eng_result = '0;
        forever begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (rst) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        eng_done = 1'b1;
                        eng_result = use_force ? force_res : eng_a * eng_b;
                    end
                end
                if (eng_start) cnt = eng_delay;
                if (noise && $urandom_range(0, 3) == 0) begin
                    eng_done = 1'b1;
                    eng_result = 16'($urandom);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit r, ok;
        ok = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1; break; end
        end
        in_valid = 1'b0;
        chk("send_accepted", ok, 1);
    endtask

    task automatic wait_outv(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); n++;
            if (out_valid) break;
        end
        chk("out_valid_seen", out_valid, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0, tprev;
        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
        in_valid1 = 0; out_ready1 = 0; eng_done1 = 0; eng_result1 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; chk_en = 1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_job_count", job_count, 0);
        step();

        // Warm-up job so the reset below has non-zero state to clear
        eng_delay = 1; out_ready = 1;
        send(8'd3, 8'd4);
        wait_outv(n);
        chk("warm_lat", n, 3);
        chk("warm_res", out_result, 16'd12);
        step();
        chk("warm_cnt", job_count, 1);

        // Asynchronous reset while waiting on the engine
        eng_delay = 0;
        send(8'h33, 8'h44);
        step(); step();
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_eng_start", eng_start, 0);
        chk("arst_eng_a", eng_a, 0);
        chk("arst_eng_b", eng_b, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_result", out_result, 0);
        chk("arst_out_timeout", out_timeout, 0);
        chk("arst_job_count", job_count, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) step();
        chk("arst_no_output", out_valid, 0);
        chk("arst_cnt_after", job_count, 0);

        // Basic job: 12*10 with done two cycles after start
        eng_delay = 2; out_ready = 1;
        s0 = nstart;
        send(8'd12, 8'd10);
        wait_outv(n);
        chk("t2_lat", n, 4);
        chk("t2_res", out_result, 16'd120);
        chk("t2_to", out_timeout, 0);
        step();
        chk("t2_cnt", job_count, 1);
        chk("t2_busy", busy, 0);
        chk("t2_start_cycles", nstart - s0, 1);

        // Timeout with a late done that must be ignored
        eng_delay = 0; out_ready = 0;
        send(8'd7, 8'd9);
        wait_outv(n);
        chk("t3_lat", n, 17);
        chk("t3_res", out_result, 0);
        chk("t3_to", out_timeout, 1);
        step();
        noise = 1;
        repeat (6) step();
        noise = 0;
        chk("t3_hold_to", out_timeout, 1);
        chk("t3_hold_cnt", job_count, 1);
        out_ready = 1;
        step();
        chk("t3_cnt", job_count, 2);
        out_ready = 0;

        // Backpressure with a stalled upstream request
        eng_delay = 1;
        send(8'd200, 8'd3);
        in_valid = 1; in_a = 8'd5; in_b = 8'd6;
        wait_outv(n);
        chk("t4_lat", n, 3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_res", out_result, 16'd600);
            chk("t4_in_ready", in_ready, 0);
        end
        out_ready = 1;
        send(8'd5, 8'd6);
        chk("t4_eng_a", eng_a, 8'd5);
        chk("t4_eng_b", eng_b, 8'd6);
        chk("t4_cnt", job_count, 3);
        wait_outv(n);
        chk("t4_res2", out_result, 16'd30);
        step();

        // done and timeout on the same edge
        eng_delay = 15; use_force = 1; force_res = 16'hBEEF; out_ready = 0;
        send(8'd1, 8'd2);
        wait_outv(n);
        chk("t5_lat", n, 17);
        chk("t5_res", out_result, 16'hBEEF);
        chk("t5_to", out_timeout, 0);
        out_ready = 1;
        step();
        use_force = 0;

        // TIMEOUT=1 instance: times out at the first WAIT edge
        in_valid1 = 1;
        step();
        in_valid1 = 0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid1) break;
            n++;
        end
        chk("to1_lat", n, 3);
        chk("to1_to", out_timeout1, 1);
        chk("to1_res", out_result1, 0);
        step();
        out_ready1 = 1;
        step();
        chk("to1_cnt", job_count1, 1);
        out_ready1 = 0;

        // 256 back-to-back jobs from a fresh reset
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1; eng_delay = 1; noise = 0;
        tprev = 0;
        for (int j = 0; j < 256; j++) begin
            send(8'($urandom), 8'($urandom));
            if (j > 0) chk("t6_spacing", tcyc - tprev, 4);
            if (j == 255) chk("t6_cnt255", job_count, 255);
            tprev = tcyc;
        end
        wait_outv(n);
        step();
        chk("t6_wrap", job_count, 0);

        // Randomized traffic
        noise = 1;
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            eng_delay = $urandom_range(0, 17);
            step();
        end
        noise = 0; in_valid = 0; out_ready = 1;
        repeat (25) step();
        chk("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
